// File: rtl/hilo_acc_pkg.sv
// Shared CPU defines for the HI/LO accumulator: multiply/divide op codes,
// the accumulator FSM states and a small op-decoding helper.
package hilo_acc_pkg;

    typedef enum logic [1:0] {
        MD_OP_WR     = 2'b00,
        MD_OP_MADD   = 2'b01,
        MD_OP_MSUB   = 2'b10,
        MD_OP_WR_ALT = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } hilo_state_e;

    // Both 00 and 11 are plain writes; only MADD/MSUB need the extra cycle.
    function automatic logic is_acc_op(input md_op_e op);
        return (op == MD_OP_MADD) || (op == MD_OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_acc_if.sv
// Bundle of the multiply/divide result port, MTHI/MTLO writes and HI/LO reads
// between the issuing pipeline (master) and the accumulator (slave).
interface hilo_acc_if #(
    parameter int DATA_W = 32
);
    import hilo_acc_pkg::*;

    logic              md_valid;
    md_op_e            md_op;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic              md_ready;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] mt_data;
    logic              flush;
    logic [DATA_W-1:0] hi_rd;
    logic [DATA_W-1:0] lo_rd;
    logic              busy;

    modport master (
        output md_valid, md_op, md_hi, md_lo, hi_we, lo_we, mt_data, flush,
        input  md_ready, hi_rd, lo_rd, busy
    );

    modport slave (
        input  md_valid, md_op, md_hi, md_lo, hi_we, lo_we, mt_data, flush,
        output md_ready, hi_rd, lo_rd, busy
    );

endinterface

// File: rtl/hilo_acc_addsub.sv
// Combinational double-width add/subtract used for the MADD/MSUB commit;
// the result wraps modulo 2^(2*DATA_W).
module hilo_acc_addsub #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] a,
    input  logic [2*DATA_W-1:0] b,
    input  logic                sub,
    output logic [2*DATA_W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with MADD/MSUB accumulate: accumulates are registered
// for one cycle (ACC) so a late flush can still cancel them before commit.
module hilo_acc
    import hilo_acc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    hilo_acc_if.slave  bus
);

    hilo_state_e         state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] opnd_q, opnd_d;
    md_op_e              op_q, op_d;

    logic                hs;
    logic                acc_hs;
    logic                wr_hs;
    logic [2*DATA_W-1:0] acc_res;

    assign bus.md_ready = (state_q == ST_IDLE);
    assign hs           = bus.md_valid && bus.md_ready;
    assign acc_hs       = hs && is_acc_op(bus.md_op);
    assign wr_hs        = hs && !is_acc_op(bus.md_op);
    assign bus.busy     = (state_q == ST_ACC) || acc_hs;

    hilo_acc_addsub #(.DATA_W(DATA_W)) u_addsub (
        .a   ({hi_q, lo_q}),
        .b   (opnd_q),
        .sub (op_q == MD_OP_MSUB),
        .y   (acc_res)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_hs) begin
                    hi_d = bus.md_hi;
                    lo_d = bus.md_lo;
                end else if (acc_hs) begin
                    opnd_d  = {bus.md_hi, bus.md_lo};
                    op_d    = bus.md_op;
                    state_d = ST_ACC;
                end else begin
                    // MT writes only land when no handshake claims HI/LO.
                    if (bus.hi_we) hi_d = bus.mt_data;
                    if (bus.lo_we) lo_d = bus.mt_data;
                end
            end
            ST_ACC: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    {hi_d, lo_d} = acc_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forward same-cycle writes so a dependent read need not wait an edge.
    always_comb begin
        bus.hi_rd = hi_q;
        bus.lo_rd = lo_q;
        if (BYPASS_EN && !bus.busy) begin
            if (wr_hs) begin
                bus.hi_rd = bus.md_hi;
                bus.lo_rd = bus.md_lo;
            end else begin
                if (bus.hi_we) bus.hi_rd = bus.mt_data;
                if (bus.lo_we) bus.lo_rd = bus.mt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= MD_OP_WR;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_hilo_acc.sv
// Randomized bench for hilo_acc: a 64-bit value/pending-op reference model
// predicts md_ready, busy and the forwarded HI/LO reads every cycle.
module tb_hilo_acc;
    import hilo_acc_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_acc_if #(.DATA_W(W)) bus ();

    hilo_acc #(.DATA_W(W), .BYPASS_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: whole HI:LO as one 64-bit number plus a pending accumulate.
    logic [63:0] m_hilo;
    logic [63:0] m_opnd;
    bit          m_pend;
    bit          m_sub;

    logic [W-1:0] obs_hi, obs_lo;
    logic         obs_rdy, obs_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input logic [W-1:0] h, input logic [W-1:0] l,
                        input bit hwe, input bit lwe, input logic [W-1:0] mt,
                        input bit fl);
        bit hs, accop, e_busy;
        logic [W-1:0] e_hi, e_lo;
        @(negedge clk);
        rst          = r;
        bus.md_valid = v;
        bus.md_op    = md_op_e'(op);
        bus.md_hi    = h;
        bus.md_lo    = l;
        bus.hi_we    = hwe;
        bus.lo_we    = lwe;
        bus.mt_data  = mt;
        bus.flush    = fl;
        #1;
        hs     = v && !m_pend;
        accop  = (op == 2'b01) || (op == 2'b10);
        e_busy = m_pend || (hs && accop);
        e_hi   = m_hilo[63:32];
        e_lo   = m_hilo[31:0];
        if (!e_busy) begin
            if (hs) begin
                e_hi = h;
                e_lo = l;
            end else begin
                if (hwe) e_hi = mt;
                if (lwe) e_lo = mt;
            end
        end
        obs_hi   = bus.hi_rd;
        obs_lo   = bus.lo_rd;
        obs_rdy  = bus.md_ready;
        obs_busy = bus.busy;
        chk("md_ready", {63'd0, obs_rdy}, {63'd0, !m_pend});
        chk("busy", {63'd0, obs_busy}, {63'd0, e_busy});
        chk("hi_rd", {32'd0, obs_hi}, {32'd0, e_hi});
        chk("lo_rd", {32'd0, obs_lo}, {32'd0, e_lo});
        @(posedge clk);
        if (r) begin
            m_hilo = 64'd0;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_pend = 1'b0;
            if (!fl) m_hilo = m_sub ? (m_hilo - m_opnd) : (m_hilo + m_opnd);
        end else if (hs && accop) begin
            m_pend = 1'b1;
            m_opnd = {h, l};
            m_sub  = (op == 2'b10);
        end else if (hs) begin
            m_hilo = {h, l};
        end else begin
            if (hwe) m_hilo[63:32] = mt;
            if (lwe) m_hilo[31:0]  = mt;
        end
    endtask

    task automatic idle();
        step(0, 0, 2'b00, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic expect_regs(input string tag, input logic [W-1:0] he, input logic [W-1:0] le);
        idle();
        chk({tag, "_hi"}, {32'd0, obs_hi}, {32'd0, he});
        chk({tag, "_lo"}, {32'd0, obs_lo}, {32'd0, le});
        chk({tag, "_rdy"}, {63'd0, obs_rdy}, 64'd1);
        chk({tag, "_busy"}, {63'd0, obs_busy}, 64'd0);
    endtask

    initial begin
        m_hilo = '0; m_opnd = '0; m_pend = 0; m_sub = 0;
        rst = 1'b1;
        bus.md_valid = 0; bus.md_op = MD_OP_WR; bus.md_hi = '0; bus.md_lo = '0;
        bus.hi_we = 0; bus.lo_we = 0; bus.mt_data = '0; bus.flush = 0;
        repeat (2) @(posedge clk);
        expect_regs("reset", 32'h0, 32'h0);

        // direct write visible the same cycle
        step(0, 1, 2'b00, 32'h1, 32'h2, 0, 0, '0, 0);
        chk("wr_fwd_hi", {32'd0, obs_hi}, 64'h1);
        chk("wr_fwd_lo", {32'd0, obs_lo}, 64'h2);
        expect_regs("wr", 32'h1, 32'h2);

        // MADD carry across halves, busy for two cycles
        step(0, 1, 2'b11, 32'h0, 32'hFFFF_FFFF, 0, 0, '0, 0);
        step(0, 1, 2'b01, 32'h0, 32'h1, 0, 0, '0, 0);
        chk("madd_busy0", {63'd0, obs_busy}, 64'd1);
        idle();
        chk("madd_busy1", {63'd0, obs_busy}, 64'd1);
        expect_regs("madd", 32'h1, 32'h0);

        // MSUB wraps below zero
        step(0, 1, 2'b00, 32'h0, 32'h0, 0, 0, '0, 0);
        step(0, 1, 2'b10, 32'h0, 32'h1, 0, 0, '0, 0);
        idle();
        expect_regs("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // flush cancels the pending accumulate
        step(0, 1, 2'b00, 32'h5, 32'h7, 0, 0, '0, 0);
        step(0, 1, 2'b01, 32'h0, 32'h3, 0, 0, '0, 0);
        step(0, 0, 2'b00, '0, '0, 1, 1, 32'h99, 1);
        expect_regs("flush", 32'h5, 32'h7);

        // handshake beats MTLO in the same cycle
        step(0, 1, 2'b00, 32'h0, 32'hA, 0, 1, 32'hB, 0);
        chk("prio_fwd_lo", {32'd0, obs_lo}, 64'hA);
        expect_regs("prio", 32'h0, 32'hA);

        // flush in IDLE is harmless; MTHI still lands
        step(0, 0, 2'b00, '0, '0, 1, 0, 32'h1234, 1);
        expect_regs("idle_flush", 32'h1234, 32'hA);

        // reset during ACC drops the accumulate
        step(0, 1, 2'b00, 32'h9, 32'h9, 0, 0, '0, 0);
        step(0, 1, 2'b01, 32'h0, 32'h1, 0, 0, '0, 0);
        step(1, 0, 2'b00, '0, '0, 0, 0, '0, 0);
        expect_regs("rst_acc", 32'h0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] rh, rl;
            rh = $urandom();
            rl = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            if ($urandom_range(0, 3) == 0) rh = $urandom_range(0, 2);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), rh, rl,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom(),
                 $urandom_range(0, 3) == 0);
        end
        expect_regs("final", m_hilo[63:32], m_hilo[31:0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, which sets the width of HI and of LO.
REQ-002 The module SHALL have parameter BYPASS_EN, default 1; when 1, same-cycle direct writes are forwarded to the read ports.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port md_valid, input, 1 bit: a multiply/divide result is presented this cycle.
REQ-006 The module SHALL have port md_op, input, 2 bits: 00 and 11 = direct write; 01 = accumulate-add (MADD); 10 = accumulate-subtract (MSUB).
REQ-007 The module SHALL have ports md_hi and md_lo, input, DATA_W bits each: the product/quotient halves.
REQ-008 The module SHALL have port md_ready, output, 1 bit: the block accepts md_valid this cycle.
REQ-009 The module SHALL have ports hi_we and lo_we, input, 1 bit each: MTHI/MTLO write enables.
REQ-010 The module SHALL have port mt_data, input, DATA_W bits: the MTHI/MTLO data.
REQ-011 The module SHALL have port flush, input, 1 bit: cancel a pending accumulate (exception).
REQ-012 The module SHALL have ports hi_rd and lo_rd, output, DATA_W bits each: HI/LO read values.
REQ-013 The module SHALL have port busy, output, 1 bit: an accumulate is pending, so readers must stall.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and ACC.
REQ-015 md_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 In IDLE, a handshake (md_valid && md_ready) with a direct-write op SHALL write HI=md_hi and LO=md_lo at the next edge, and the state SHALL stay IDLE.
REQ-017 In IDLE, a handshake with op 01 or 10 SHALL register {md_hi,md_lo} and the op, and the FSM SHALL go to ACC.
REQ-018 In ACC without flush, the next edge SHALL commit {HI,LO} = {HI,LO} +/- operand, computed at 2*DATA_W bits and wrapping modulo 2^(2*DATA_W), and the FSM SHALL return to IDLE.
REQ-019 In ACC with flush=1, the commit SHALL be discarded, HI/LO SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-020 A handshake SHALL take priority over hi_we/lo_we in the same cycle; the losing MT write is dropped.
REQ-021 In ACC, hi_we/lo_we SHALL be ignored, because the issuing stage is stalled by busy.
REQ-022 busy SHALL be 1 when the state is ACC, or when an accumulate handshake occurs this cycle.
REQ-023 When BYPASS_EN=1 and busy=0, hi_rd/lo_rd SHALL show, in priority order: the direct-write handshake data, then mt_data for the enabled half, then the register value.
REQ-024 When busy=1 or BYPASS_EN=0, hi_rd/lo_rd SHALL equal the HI/LO registers.
REQ-025 When flush is asserted in IDLE, it SHALL have no effect.

Reset
REQ-026 When rst=1 at a clock edge, HI, LO and the operand register SHALL be set to 0 and the FSM SHALL go to IDLE, with md_ready=1 and busy=0 on the next cycle.
REQ-027 A reset while in ACC SHALL discard the pending accumulate.
REQ-028 rst SHALL override md_valid, hi_we, lo_we and flush.

Structure
REQ-029 The md_op encodings and the FSM state enum SHALL be defined in the shared CPU defines package and not locally.
REQ-030 The 2*DATA_W add/subtract SHALL be implemented in a single sub-module, hilo_acc_addsub, which is purely combinational.
REQ-031 All registers SHALL live in hilo_acc; no latches are permitted.

Verification
REQ-032 Scenario: after reset, drive md_valid with op=00, md_hi=0x1, md_lo=0x2 -> hi_rd=0x1 and lo_rd=0x2 in the same cycle; registers hold these values after the edge.
REQ-033 Scenario: with HI=0, LO=0xFFFFFFFF, issue op=01 with operand 0x0000_0000_0000_0001 -> busy=1 for 2 cycles, then HI=0x1 and LO=0x0 (carry crosses the halves).
REQ-034 Scenario: with HI=LO=0, issue op=10 with operand 1 -> HI=LO=0xFFFFFFFF (wrap-around).
REQ-035 Scenario: issue op=01, then assert flush in the ACC cycle -> HI/LO unchanged and md_ready=1 on the next cycle.
REQ-036 Scenario: assert md_valid op=00 (md_lo=0xA) together with lo_we=1 (mt_data=0xB) -> LO=0xA.
REQ-037 Scenario: assert rst while in ACC -> HI=LO=0, busy=0, md_ready=1 on the next cycle, and no commit occurs.
